cm0_pmu_gate_ctrl: RTL and testbench
====================================

Name: cm0_pmu_gate_ctrl

Overview:
Sleep/wake sequencer that drives the ENABLE input of the architectural clock gate cell (cm0_pmu_acg) for the gated core clock.
- Entering sleep: drains for a programmable number of idle cycles, then gates the clock and acknowledges.
- Leaving sleep: ungates the clock on wake, allows a settle interval, then drops the acknowledge.
- Runs on the free-running clock, between core sleep signalling and the clock gate.

Parameters:
ACG, 1, 1 = clock gating implemented; 0 = GATE_EN tied high, handshake still operates.
DRAIN_CYCLES, 4, idle cycles spent in DRAIN before gating (0..2^CNT_W-1).
WAKE_CYCLES, 2, settle cycles in WAKEUP before SLEEP_ACK falls (0..2^CNT_W-1).
CNT_W, 4, down-counter width.

Ports:
FCLK  input  1  free-running clock; all logic is rising-edge.
RESET  input  1  synchronous, active-high reset.
SLEEP_REQ  input  1  core requests sleep; four-phase with SLEEP_ACK.
WAKE_REQ  input  1  wake event (level; WIC/interrupt).
DBG_ACTIVE  input  1  debugger attached; blocks or aborts gating.
DFT_BYPASS  input  1  scan bypass; passed to the gate BYPASS input only.
SLEEP_ACK  output  1  clock is gated or being restored; registered.
GATE_EN  output  1  clock-gate enable; registered.
GCLK  output  1  gated clock from the internal cm0_pmu_acg instance (FCLK, GATE_EN, DFT_BYPASS).
STATE  output  2  current FSM state, for debug visibility.

Behaviour:
- Reset values: STATE=RUN, GATE_EN=1, SLEEP_ACK=0, cnt=0, armed=1.
- States: RUN=2'b00, DRAIN=2'b01, GATED=2'b10, WAKEUP=2'b11. `abort = WAKE_REQ | ~SLEEP_REQ | DBG_ACTIVE`.
- RUN:
  - armed is set whenever SLEEP_REQ=0.
  - If SLEEP_REQ & armed & ~WAKE_REQ & ~DBG_ACTIVE -> DRAIN, cnt<=DRAIN_CYCLES, armed<=0.
- DRAIN:
  - If abort -> RUN, with no ack and no gating; armed is then re-set only after SLEEP_REQ is seen low.
  - Else if cnt==0 -> GATED, else cnt<=cnt-1.
  - DRAIN therefore lasts DRAIN_CYCLES+1 cycles.
- GATED:
  - GATE_EN=0 (1 when ACG=0), SLEEP_ACK=1.
  - On abort -> WAKEUP, cnt<=WAKE_CYCLES, GATE_EN<=1 on the same edge.
- WAKEUP:
  - GATE_EN=1, SLEEP_ACK held 1.
  - When cnt==0 -> RUN with SLEEP_ACK<=0, else cnt<=cnt-1.
  - WAKEUP ignores inputs; it is not abortable.
- Output timing: GATE_EN and SLEEP_ACK are registered with the state transition and have no combinational path from inputs.
- Latency, SLEEP_REQ first sampled high at edge k (RUN, armed): DRAIN from k; GATED, GATE_EN=0 and SLEEP_ACK=1 at edge k+DRAIN_CYCLES+1.
- Latency, wake sampled at edge m in GATED: GATE_EN=1 at m; RUN and SLEEP_ACK=0 at m+WAKE_CYCLES+1.
- Simultaneous events: WAKE_REQ and SLEEP_REQ rising in the same RUN cycle -> stay in RUN. DBG_ACTIVE has priority equal to WAKE_REQ.
- Re-entry: SLEEP_REQ held high after exiting to RUN does not re-enter sleep; it must drop for at least one cycle (armed).
- RESET asserted in any state returns to reset values on the next edge. GATE_EN returns to 1 at that edge, so the clock is restored.
- Counter never underflows; cnt is loaded only on DRAIN/WAKEUP entry.
- DFT_BYPASS does not affect the FSM.

Decomposition:
- Package cm0_pmu_pkg: state encoding localparams (RUN/DRAIN/GATED/WAKEUP) and default cycle constants.
- Sub-module cm0_pmu_gate_cnt: loadable CNT_W down-counter with load, dec and zero flag.
- Top level: FSM, armed flag, and the cm0_pmu_acg instance.

Test Plan:
- Reset, then SLEEP_REQ=1 with defaults -> STATE=DRAIN next edge; GATE_EN=0 and SLEEP_ACK=1 exactly 5 edges after first sample; GCLK stops.
- From GATED, pulse WAKE_REQ for 1 cycle -> GATE_EN=1 at that edge, GCLK resumes; SLEEP_ACK=0 and STATE=RUN 3 edges later.
- WAKE_REQ asserted on DRAIN cycle 2 -> RUN next edge, GATE_EN never 0, SLEEP_ACK never 1; SLEEP_REQ kept high -> stays RUN until SLEEP_REQ drops and re-rises.
- DBG_ACTIVE=1 with SLEEP_REQ=1 -> remains RUN indefinitely. DBG_ACTIVE raised in GATED -> WAKEUP, clock restored.
- RESET pulsed while GATED -> next edge GATE_EN=1, SLEEP_ACK=0, STATE=RUN; DRAIN_CYCLES=0 variant -> GATED 1 edge after request.
- ACG=0 build: full sleep/wake handshake timing identical, GATE_EN constantly 1, GCLK==FCLK; DFT_BYPASS=1 in GATED (ACG=1) -> GCLK toggles, STATE unchanged.

Source files
------------

// File: rtl/cm0_pmu_pkg.sv
// Shared definitions for the PMU clock-gate sequencer: FSM encoding and default timing.
package cm0_pmu_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_GATED  = 2'b10,
        ST_WAKEUP = 2'b11
    } pmu_state_e;

    localparam int unsigned PMU_DRAIN_CYCLES_DEF = 4;
    localparam int unsigned PMU_WAKE_CYCLES_DEF  = 2;
    localparam int unsigned PMU_CNT_W_DEF        = 4;

    // SLEEP_ACK is high while the clock is gated or still being restored.
    function automatic logic state_is_asleep(input pmu_state_e s);
        return (s == ST_GATED) || (s == ST_WAKEUP);
    endfunction

endpackage

// File: rtl/cm0_pmu_acg.sv
// Latch-based architectural clock gate; enable (or scan bypass) is captured while the clock is low.
module cm0_pmu_acg (
    input  logic clk_i,
    input  logic en_i,
    input  logic bypass_i,
    output logic gclk_o
);

    logic en_lat_q;

    always_latch begin
        if (!clk_i) begin
            en_lat_q <= en_i | bypass_i;
        end
    end

    assign gclk_o = clk_i & en_lat_q;

endmodule

// File: rtl/cm0_pmu_gate_cnt.sv
// Loadable down-counter used for the DRAIN and WAKEUP intervals; saturates at zero.
module cm0_pmu_gate_cnt
    import cm0_pmu_pkg::*;
#(
    parameter int unsigned CNT_W = PMU_CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cm0_pmu_gate_ctrl.sv
// Sleep/wake sequencer driving the core clock gate: drain, gate and acknowledge, then restore and settle.
module cm0_pmu_gate_ctrl
    import cm0_pmu_pkg::*;
#(
    parameter bit          ACG          = 1'b1,
    parameter int unsigned DRAIN_CYCLES = PMU_DRAIN_CYCLES_DEF,
    parameter int unsigned WAKE_CYCLES  = PMU_WAKE_CYCLES_DEF,
    parameter int unsigned CNT_W        = PMU_CNT_W_DEF
) (
    input  logic       FCLK,
    input  logic       RESET,
    input  logic       SLEEP_REQ,
    input  logic       WAKE_REQ,
    input  logic       DBG_ACTIVE,
    input  logic       DFT_BYPASS,
    output logic       SLEEP_ACK,
    output logic       GATE_EN,
    output logic       GCLK,
    output logic [1:0] STATE
);

    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_CYCLES);

    pmu_state_e       state_q, state_d;
    logic             armed_q, armed_d;
    logic             gate_en_q, gate_en_d;
    logic             ack_q, ack_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             abort;

    assign abort = WAKE_REQ | ~SLEEP_REQ | DBG_ACTIVE;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            ST_RUN: begin
                if (!SLEEP_REQ) begin
                    armed_d = 1'b1;
                end else if (armed_q && !WAKE_REQ && !DBG_ACTIVE) begin
                    state_d  = ST_DRAIN;
                    armed_d  = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = DRAIN_LD;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_RUN;
                end else if (cnt_zero) begin
                    state_d = ST_GATED;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GATED: begin
                if (abort) begin
                    state_d  = ST_WAKEUP;
                    cnt_load = 1'b1;
                    cnt_val  = WAKE_LD;
                end
            end
            ST_WAKEUP: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs are derived from the next state so they register on the same edge as the transition.
    always_comb begin
        gate_en_d = (state_d == ST_GATED) ? ~ACG : 1'b1;
        ack_d     = state_is_asleep(state_d);
    end

    always_ff @(posedge FCLK) begin
        if (RESET) begin
            state_q   <= ST_RUN;
            armed_q   <= 1'b1;
            gate_en_q <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            gate_en_q <= gate_en_d;
            ack_q     <= ack_d;
        end
    end

    cm0_pmu_gate_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk_i      (FCLK),
        .rst_i      (RESET),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    cm0_pmu_acg u_acg (
        .clk_i    (FCLK),
        .en_i     (gate_en_q),
        .bypass_i (DFT_BYPASS),
        .gclk_o   (GCLK)
    );

    assign GATE_EN   = gate_en_q;
    assign SLEEP_ACK = ack_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_cm0_pmu_gate_ctrl.sv
// Bench for cm0_pmu_gate_ctrl: three builds (default, ACG=0, zero-length intervals) share one stimulus stream.
module tb_cm0_pmu_gate_ctrl;

    localparam int NI = 3;
    localparam int P_ACG[NI]   = '{1, 0, 1};
    localparam int P_DRAIN[NI] = '{4, 4, 0};
    localparam int P_WAKE[NI]  = '{2, 2, 0};

    logic FCLK = 1'b0;
    logic RESET, SLEEP_REQ, WAKE_REQ, DBG_ACTIVE, DFT_BYPASS;
    logic [NI-1:0]      ack, gen, gclk;
    logic [NI-1:0][1:0] st;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: phase 0=run 1=drain 2=gated 3=wakeup, plus remaining-interval and re-arm bookkeeping.
    int m_ph[NI];
    int m_rem[NI];
    bit m_armed[NI];
    bit m_prev_gen[NI];

    always #5 FCLK = ~FCLK;

    cm0_pmu_gate_ctrl #(.ACG(1), .DRAIN_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(4)) u_dut0 (
        .FCLK(FCLK), .RESET(RESET), .SLEEP_REQ(SLEEP_REQ), .WAKE_REQ(WAKE_REQ),
        .DBG_ACTIVE(DBG_ACTIVE), .DFT_BYPASS(DFT_BYPASS), .SLEEP_ACK(ack[0]),
        .GATE_EN(gen[0]), .GCLK(gclk[0]), .STATE(st[0]));

    cm0_pmu_gate_ctrl #(.ACG(0), .DRAIN_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(4)) u_dut1 (
        .FCLK(FCLK), .RESET(RESET), .SLEEP_REQ(SLEEP_REQ), .WAKE_REQ(WAKE_REQ),
        .DBG_ACTIVE(DBG_ACTIVE), .DFT_BYPASS(DFT_BYPASS), .SLEEP_ACK(ack[1]),
        .GATE_EN(gen[1]), .GCLK(gclk[1]), .STATE(st[1]));

    cm0_pmu_gate_ctrl #(.ACG(1), .DRAIN_CYCLES(0), .WAKE_CYCLES(0), .CNT_W(4)) u_dut2 (
        .FCLK(FCLK), .RESET(RESET), .SLEEP_REQ(SLEEP_REQ), .WAKE_REQ(WAKE_REQ),
        .DBG_ACTIVE(DBG_ACTIVE), .DFT_BYPASS(DFT_BYPASS), .SLEEP_ACK(ack[2]),
        .GATE_EN(gen[2]), .GCLK(gclk[2]), .STATE(st[2]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_gen(input int i);
        return !(m_ph[i] == 2 && P_ACG[i] == 1);
    endfunction

    function automatic bit exp_ack(input int i);
        return m_ph[i] >= 2;
    endfunction

    // Model advance and per-cycle compare; inputs only change mid high-phase, so they are stable here.
    always @(posedge FCLK) begin
        bit ab;
        ab = WAKE_REQ | ~SLEEP_REQ | DBG_ACTIVE;
        for (int i = 0; i < NI; i++) begin
            m_prev_gen[i] = exp_gen(i);
            if (RESET) begin
                m_ph[i] = 0; m_rem[i] = 0; m_armed[i] = 1'b1;
            end else begin
                case (m_ph[i])
                    0: if (!SLEEP_REQ) m_armed[i] = 1'b1;
                       else if (m_armed[i] && !WAKE_REQ && !DBG_ACTIVE) begin
                           m_ph[i] = 1; m_rem[i] = P_DRAIN[i]; m_armed[i] = 1'b0;
                       end
                    1: if (ab) m_ph[i] = 0;
                       else if (m_rem[i] == 0) m_ph[i] = 2;
                       else m_rem[i]--;
                    2: if (ab) begin m_ph[i] = 3; m_rem[i] = P_WAKE[i]; end
                    default: if (m_rem[i] == 0) m_ph[i] = 0; else m_rem[i]--;
                endcase
            end
        end
        #1;
        cyc++;
        if (cyc > 3) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model_state[%0d]", i), int'(st[i]), m_ph[i]);
                chk($sformatf("model_gate_en[%0d]", i), int'(gen[i]), int'(exp_gen(i)));
                chk($sformatf("model_ack[%0d]", i), int'(ack[i]), int'(exp_ack(i)));
                chk($sformatf("model_gclk_hi[%0d]", i), int'(gclk[i]), int'(m_prev_gen[i] | DFT_BYPASS));
            end
        end
    end

    always @(negedge FCLK) begin
        if (cyc > 3) begin
            for (int i = 0; i < NI; i++) chk($sformatf("gclk_lo[%0d]", i), int'(gclk[i]), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge FCLK);
            #2;
        end
    endtask

    initial begin
        RESET = 1'b1; SLEEP_REQ = 1'b0; WAKE_REQ = 1'b0; DBG_ACTIVE = 1'b0; DFT_BYPASS = 1'b0;
        tick(3);
        chk("rst_state", int'(st[0]), 0);
        chk("rst_gate_en", int'(gen[0]), 1);
        chk("rst_ack", int'(ack[0]), 0);
        RESET = 1'b0;
        tick(1);

        // Sleep entry: DRAIN at edge k, GATED at k+5 (default) and k+1 (zero drain).
        SLEEP_REQ = 1'b1;
        tick(1);
        chk("entry_drain0", int'(st[0]), 1);
        chk("entry_drain2", int'(st[2]), 1);
        tick(1);
        chk("d0_gated2", int'(st[2]), 2);
        chk("d0_gate_en2", int'(gen[2]), 0);
        chk("still_drain0", int'(st[0]), 1);
        tick(3);
        chk("k4_drain0", int'(st[0]), 1);
        chk("k4_ack0", int'(ack[0]), 0);
        tick(1);
        chk("k5_gated0", int'(st[0]), 2);
        chk("k5_gate_en0", int'(gen[0]), 0);
        chk("k5_ack0", int'(ack[0]), 1);
        chk("acg0_gate_en1", int'(gen[1]), 1);
        chk("acg0_gated1", int'(st[1]), 2);
        tick(1);
        chk("gclk_stopped0", int'(gclk[0]), 0);
        chk("gclk_free1", int'(gclk[1]), 1);

        DFT_BYPASS = 1'b1;
        tick(1);
        chk("bypass_gclk0", int'(gclk[0]), 1);
        chk("bypass_state0", int'(st[0]), 2);
        DFT_BYPASS = 1'b0;
        tick(1);
        chk("unbypass_gclk0", int'(gclk[0]), 0);

        // Wake pulse: gate opens at edge m, RUN at m+3.
        WAKE_REQ = 1'b1;
        tick(1);
        chk("wake_gate_en0", int'(gen[0]), 1);
        chk("wake_state0", int'(st[0]), 3);
        chk("wake_ack0", int'(ack[0]), 1);
        WAKE_REQ = 1'b0;
        tick(2);
        chk("m2_state0", int'(st[0]), 3);
        tick(1);
        chk("m3_state0", int'(st[0]), 0);
        chk("m3_ack0", int'(ack[0]), 0);
        tick(4);
        chk("no_reentry0", int'(st[0]), 0);

        // Re-arm, then abort from DRAIN with a wake event.
        SLEEP_REQ = 1'b0;
        tick(1);
        SLEEP_REQ = 1'b1;
        tick(1);
        chk("rearm_drain0", int'(st[0]), 1);
        tick(1);
        WAKE_REQ = 1'b1;
        tick(1);
        chk("abort_run0", int'(st[0]), 0);
        chk("abort_gate_en0", int'(gen[0]), 1);
        WAKE_REQ = 1'b0;
        tick(8);
        chk("abort_hold_run0", int'(st[0]), 0);

        // Debugger blocks entry, then forces wake from GATED.
        SLEEP_REQ = 1'b0;
        tick(1);
        DBG_ACTIVE = 1'b1;
        SLEEP_REQ = 1'b1;
        tick(8);
        chk("dbg_block0", int'(st[0]), 0);
        DBG_ACTIVE = 1'b0;
        tick(6);
        chk("dbg_gated0", int'(st[0]), 2);
        DBG_ACTIVE = 1'b1;
        tick(1);
        chk("dbg_wake0", int'(st[0]), 3);
        chk("dbg_gate_en0", int'(gen[0]), 1);
        DBG_ACTIVE = 1'b0;
        SLEEP_REQ = 1'b0;
        tick(4);

        // Reset while gated.
        SLEEP_REQ = 1'b1;
        tick(6);
        chk("pre_rst_gated0", int'(st[0]), 2);
        RESET = 1'b1;
        tick(1);
        chk("rst_gated_state0", int'(st[0]), 0);
        chk("rst_gated_gate_en0", int'(gen[0]), 1);
        chk("rst_gated_ack0", int'(ack[0]), 0);
        RESET = 1'b0;

        // Randomized traffic checked against the reference every cycle.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 11) == 0) SLEEP_REQ = ~SLEEP_REQ;
            WAKE_REQ   = ($urandom_range(0, 15) == 0);
            DBG_ACTIVE = ($urandom_range(0, 39) == 0);
            DFT_BYPASS = ($urandom_range(0, 7) == 0);
            RESET      = ($urandom_range(0, 299) == 0);
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
